// File: rtl/dadda_pkg.sv
// Shared constants and elaboration-time column bookkeeping for the 16x16 Dadda tree.
package dadda_pkg;

    localparam int unsigned W        = 16;
    localparam int unsigned PW       = 32;
    localparam int unsigned NSTEP    = 6;
    // Number of reduction steps done before the s1 register.
    localparam int unsigned PIPE_CUT = 3;
    // Upper bound on counters placed in one column during one step.
    localparam int unsigned MAXC     = 8;

    localparam int unsigned DADDA_D [NSTEP] = '{13, 9, 6, 4, 3, 2};

    typedef enum logic [1:0] {
        InfoHeight,
        InfoCarryIn,
        InfoFull,
        InfoHalf
    } info_e;

    // Height of column k in the raw AND array.
    function automatic int unsigned pp_height(int unsigned k);
        if (k < W) return k + 1;
        if (k < 2 * W - 1) return 2 * W - 1 - k;
        return 0;
    endfunction

    // Replays the Dadda schedule and reports, for step s and column k, the
    // incoming height, carries arriving from column k-1, and the number of
    // full/half adders placed there. Carries leaving column PW-1 are dropped.
    function automatic int unsigned col_info(int unsigned s, int unsigned k, info_e sel);
        int unsigned h [PW];
        int unsigned cin;
        int unsigned tot;
        int unsigned ex;
        int unsigned nf;
        int unsigned nh;
        int unsigned res;
        res = 0;
        for (int unsigned c = 0; c < PW; c++) h[c] = pp_height(c);
        for (int unsigned st = 0; st <= s && st < NSTEP; st++) begin
            cin = 0;
            for (int unsigned c = 0; c < PW; c++) begin
                tot = h[c] + cin;
                ex  = (tot > DADDA_D[st]) ? tot - DADDA_D[st] : 0;
                nf  = ex / 2;
                nh  = ex % 2;
                if (st == s && c == k) begin
                    unique case (sel)
                        InfoHeight:  res = h[c];
                        InfoCarryIn: res = cin;
                        InfoFull:    res = nf;
                        InfoHalf:    res = nh;
                        default:     res = 0;
                    endcase
                end
                h[c] = tot - 2 * nf - nh;
                cin  = nf + nh;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dadda_csa_cell.sv
// Single reduction counter: 3:2 full adder, or 2:2 half adder when HALF is set.
module dadda_csa_cell #(
    parameter bit HALF = 1'b0
) (
    input  logic i_x,
    input  logic i_y,
    input  logic i_z,
    output logic o_sum,
    output logic o_carry
);

    if (HALF) begin : g_half
        logic w_unused_z;
        assign w_unused_z = i_z;
        assign o_sum      = i_x ^ i_y;
        assign o_carry    = i_x & i_y;
    end else begin : g_full
        assign o_sum   = i_x ^ i_y ^ i_z;
        assign o_carry = (i_x & i_y) | (i_z & (i_x ^ i_y));
    end

endmodule

// File: rtl/dadda_reduce_pipe.sv
// Two-stage 16x16 partial-product generator and Dadda reduction to two 32-bit rows.
// Stage 1: AND array + steps 16->13->9->6; stage 2: steps 6->4->3->2.
module dadda_reduce_pipe
    import dadda_pkg::*;
#(
    parameter int unsigned W  = 16,  // only 16 is supported by the fixed schedule
    parameter int unsigned PW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] row0,
    output logic [PW-1:0] row1
);

    // Column-major bit pools: [column][slot], slots above the live height are 0.
    logic [PW-1:0][W-1:0] w_pp;
    logic [PW-1:0][W-1:0] r_s1;
    logic [PW-1:0][W-1:0] w_fin;
    logic [PW-1:0]        w_row0;
    logic [PW-1:0]        w_row1;
    logic [PW-1:0]        r_row0;
    logic [PW-1:0]        r_row1;
    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic                 w_s1_load;
    logic                 w_s2_load;
    logic                 w_unused_fin;

    for (genvar k = 0; k < PW; k++) begin : g_pp
        localparam int unsigned LO = (k >= W) ? k - W + 1 : 0;
        for (genvar r = 0; r < W; r++) begin : g_bit
            if (r < pp_height(k)) begin : g_and
                assign w_pp[k][r] = a[k-LO-r] & b[LO+r];
            end else begin : g_zero
                assign w_pp[k][r] = 1'b0;
            end
        end
    end

    for (genvar s = 0; s < NSTEP; s++) begin : g_step
        logic [PW-1:0][W-1:0]    w_in;
        logic [PW-1:0][W-1:0]    w_nxt;
        logic [PW-1:0][MAXC-1:0] w_sum;
        logic [PW-1:0][MAXC-1:0] w_carry;
        logic                    w_unused_bits;

        if (s == 0) begin : g_src_pp
            assign w_in = w_pp;
        end else if (s == PIPE_CUT) begin : g_src_reg
            assign w_in = r_s1;
        end else begin : g_src_prev
            assign w_in = g_step[s-1].w_nxt;
        end

        for (genvar k = 0; k < PW; k++) begin : g_col
            localparam int unsigned HIN   = col_info(s, k, InfoHeight);
            localparam int unsigned CIN   = col_info(s, k, InfoCarryIn);
            localparam int unsigned NF    = col_info(s, k, InfoFull);
            localparam int unsigned NH    = col_info(s, k, InfoHalf);
            localparam int unsigned NCELL = NF + NH;
            localparam int unsigned USED  = 3 * NF + 2 * NH;
            localparam int unsigned REM   = HIN - USED;

            // Counters only consume this column's incoming bits, so one FA level per step.
            for (genvar j = 0; j < MAXC; j++) begin : g_cell
                if (j < NF) begin : g_fa
                    dadda_csa_cell #(.HALF(1'b0)) u_cell (
                        .i_x    (w_in[k][3*j]),
                        .i_y    (w_in[k][3*j+1]),
                        .i_z    (w_in[k][3*j+2]),
                        .o_sum  (w_sum[k][j]),
                        .o_carry(w_carry[k][j])
                    );
                end else if (j < NCELL) begin : g_ha
                    dadda_csa_cell #(.HALF(1'b1)) u_cell (
                        .i_x    (w_in[k][3*NF+2*(j-NF)]),
                        .i_y    (w_in[k][3*NF+2*(j-NF)+1]),
                        .i_z    (1'b0),
                        .o_sum  (w_sum[k][j]),
                        .o_carry(w_carry[k][j])
                    );
                end else begin : g_none
                    assign w_sum[k][j]   = 1'b0;
                    assign w_carry[k][j] = 1'b0;
                end
            end

            // Next pool: untouched bits, then carries from column k-1, then sums.
            for (genvar r = 0; r < W; r++) begin : g_slot
                if (r < REM) begin : g_pass
                    assign w_nxt[k][r] = w_in[k][USED+r];
                end else if (r < REM + CIN) begin : g_cin
                    assign w_nxt[k][r] = w_carry[k-1][r-REM];
                end else if (r < REM + CIN + NCELL) begin : g_sum
                    assign w_nxt[k][r] = w_sum[k][r-REM-CIN];
                end else begin : g_zero
                    assign w_nxt[k][r] = 1'b0;
                end
            end
        end

        // Empty slots and carries out of the top column are intentionally dropped.
        assign w_unused_bits = ^{w_in, w_sum, w_carry};
    end

    assign w_fin        = g_step[NSTEP-1].w_nxt;
    assign w_unused_fin = ^w_fin;

    // Final height is 2: slot 0 feeds row0, slot 1 feeds row1.
    always_comb begin
        w_row0 = '0;
        w_row1 = '0;
        for (int k = 0; k < PW; k++) begin
            w_row0[k] = w_fin[k][0];
            w_row1[k] = w_fin[k][1];
        end
    end

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Stage 1: capture height-6 columns; bubbles only clear the valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1 <= g_step[PIPE_CUT-1].w_nxt;
        end
    end

    // Stage 2: capture the two final rows; held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_row0     <= '0;
            r_row1     <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_row0 <= w_row0;
                r_row1 <= w_row1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign row0      = r_row0;
    assign row1      = r_row1;

endmodule

// File: tb/tb_dadda_reduce_pipe.sv
// Self-checking bench for dadda_reduce_pipe: queue-based product model plus
// a prefix-adder model of the downstream final adder.
module tb_dadda_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] row0;
    logic [31:0] row1;

    int n_checks = 0;
    int n_errors = 0;
    int n_emit   = 0;
    int cyc      = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_r0;
    logic [31:0] prev_r1;

    dadda_reduce_pipe #(.W(16), .PW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .row0     (row0),
        .row1     (row1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    // Brent-Kung prefix adder, Cin = 0, carry out ignored.
    function automatic logic [31:0] bk_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] gg;
        logic [31:0] pp;
        logic [31:0] s;
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pp = p;
        for (int d = 1; d < 32; d = d * 2) begin
            for (int i = 2 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        for (int d = 8; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < 32; i = i + 2 * d) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        s[0] = p[0];
        for (int i = 1; i < 32; i++) s[i] = p[i] ^ gg[i-1];
        return s;
    endfunction

    // Scoreboard: handshakes seen at the negedge are the ones taken at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_row0", row0, prev_r0);
                chk("stall_row1", row1, prev_r1);
            end
            if (out_valid && out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    chk("emit_unexpected", {31'b0, out_valid}, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("row_sum", row0 + row1, exp_v);
                    chk("bk_sum", bk_add(row0, row1), exp_v);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(prod(a, b));
            prev_stall = out_valid && !out_ready;
            prev_r0    = row0;
            prev_r1    = row1;
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv);
        logic took;
        int   n;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        n        = 0;
        took     = 1'b0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 200);
        chk("send_accept", {31'b0, took}, 32'd1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n         = 0;
        while ((out_valid || exp_q.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic lit(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] expv,
                       input string name);
        int n;
        drain();
        send(av, bv);
        in_valid = 1'b0;
        n        = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk(name, row0 + row1, expv);
    endtask

    initial begin
        int          c0;
        int          e0;
        int          acc;
        int          sent;
        logic        took;
        logic        stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        // Reset state, then first pair right after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_row0", row0, 32'd0);
        chk("rst_row1", row1, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b1;
        a        = 16'h0003;
        b        = 16'h0005;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_edge1_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2_valid", {31'b0, out_valid}, 32'd1);
        chk("first_sum", row0 + row1, 32'h0000000F);

        // Extremes and a hand-computed mid value.
        lit(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max_sq");
        lit(16'h0000, 16'hFFFF, 32'h00000000, "zero_a");
        lit(16'h8000, 16'h8000, 32'h40000000, "msb_sq");
        lit(16'h1234, 16'h5678, 32'h06260060, "mid_val");

        // Back-to-back streaming.
        drain();
        c0 = cyc;
        e0 = n_emit;
        for (int i = 0; i < 100; i++) send(16'($urandom), 16'($urandom));
        in_valid = 1'b0;
        chk("stream_cycles", 32'(cyc - c0), 32'd100);
        drain();
        chk("stream_emits", 32'(n_emit - e0), 32'd100);

        // Backpressure: 5 stalled cycles while offering pairs.
        e0        = n_emit;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 16'($urandom);
        b         = 16'($urandom);
        acc       = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        drain();
        chk("bp_no_loss", 32'(n_emit - e0), 32'(acc));

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_row0", row0, 32'd0);
        chk("mid_rst_row1", row1, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        stale     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            stale = stale | out_valid;
        end
        chk("no_stale", {31'b0, stale}, 32'd0);
        lit(16'hABCD, 16'h0002, 32'h0001579A, "post_rst");

        // Random throttle on both sides.
        drain();
        e0   = n_emit;
        sent = 0;
        c0   = cyc;
        in_valid = 1'b0;
        while (sent < 10000 && (cyc - c0) < 70000) begin
            if (!in_valid && ($urandom % 2 == 1)) begin
                in_valid = 1'b1;
                a        = 16'($urandom);
                b        = 16'($urandom);
            end
            out_ready = 1'($urandom % 2);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("throttle_pairs", 32'(sent), 32'd10000);
        drain();
        chk("throttle_emits", 32'(n_emit - e0), 32'(sent));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
